// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: scoreboard, stall/flush/freeze, forwarding.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             CLOCK,
   input  logic             RST_n,
   input  logic [4:0]       rs1_ID,
   input  logic [4:0]       rs2_ID,
   input  logic             use_rs1_ID,
   input  logic             use_rs2_ID,
   input  logic [4:0]       rd_ID,
   input  logic             RegWrite_ID,
   input  logic             MemRead_ID,
   input  logic             PCSrc_EX,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             stall_IF,
   output logic             bubble_EX,
   output logic             flush_ID,
   output logic             freeze,
   output logic [1:0]       fwd_A,
   output logic [1:0]       fwd_B,
   output logic             busy,
   output logic [CNT_W-1:0] perf_stall,
   output logic [CNT_W-1:0] perf_flush,
   output logic [CNT_W-1:0] perf_wait
);

   typedef enum logic [1:0] {RUN, LD_STALL, FLUSH, MEM_WAIT} state_t;
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
   } slot_t;

   localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

   state_t     state, ret_state, run_state, nxt_state;
   slot_t      sb_ex, sb_mem, sb_wb;
   logic [4:0] ex_rs1, ex_rs2;
   logic [1:0] cnt, nxt_cnt;
   logic       hold_stall, hold_bubble, hold_flush;
   logic       freeze_c, load_use, stall_c, bubble_c, flush_c;
   logic       unused_wb_memread;

   assign unused_wb_memread = sb_wb.memread;

   // A load sitting in MEM cannot forward; its data only exists from WB.
   function automatic logic [1:0] fwd_sel(input slot_t m, input slot_t w, input logic [4:0] rs);
      if (m.valid && m.regwrite && !m.memread && m.rd != 5'd0 && m.rd == rs)
         fwd_sel = 2'b01;
      else if (w.valid && w.regwrite && w.rd != 5'd0 && w.rd == rs)
         fwd_sel = 2'b10;
      else
         fwd_sel = 2'b00;
   endfunction

   always_comb begin
      freeze_c  = mem_req & ~mem_ready;
      run_state = (state == MEM_WAIT) ? ret_state : state;
      load_use  = sb_ex.valid & sb_ex.memread & (sb_ex.rd != 5'd0) &
                  ((use_rs1_ID & (rs1_ID == sb_ex.rd)) | (use_rs2_ID & (rs2_ID == sb_ex.rd)));
      stall_c   = 1'b0;
      bubble_c  = 1'b0;
      flush_c   = 1'b0;
      nxt_state = RUN;
      nxt_cnt   = cnt;
      if (PCSrc_EX) begin
         flush_c   = 1'b1;
         bubble_c  = 1'b1;
         nxt_cnt   = CNT_INIT;
         nxt_state = (CNT_INIT != 2'd0) ? FLUSH : RUN;
      end else if (run_state == FLUSH) begin
         flush_c   = 1'b1;
         nxt_cnt   = cnt - 2'd1;
         nxt_state = (cnt == 2'd1) ? RUN : FLUSH;
      end else if (run_state == RUN && load_use) begin
         stall_c   = 1'b1;
         bubble_c  = 1'b1;
         nxt_state = LD_STALL;
      end
   end

   // While frozen the controls replay the last live cycle so the datapath sees no change.
   always_comb begin
      stall_IF  = 1'b0;
      bubble_EX = 1'b0;
      flush_ID  = 1'b0;
      freeze    = 1'b0;
      fwd_A     = 2'b00;
      fwd_B     = 2'b00;
      busy      = 1'b0;
      if (RST_n) begin
         freeze    = freeze_c;
         stall_IF  = freeze_c ? hold_stall  : stall_c;
         bubble_EX = freeze_c ? hold_bubble : bubble_c;
         flush_ID  = freeze_c ? hold_flush  : flush_c;
         fwd_A     = fwd_sel(sb_mem, sb_wb, ex_rs1);
         fwd_B     = fwd_sel(sb_mem, sb_wb, ex_rs2);
         busy      = (state != RUN);
      end
   end

   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         state       <= RUN;
         ret_state   <= RUN;
         cnt         <= 2'd0;
         sb_ex       <= '0;
         sb_mem      <= '0;
         sb_wb       <= '0;
         ex_rs1      <= 5'd0;
         ex_rs2      <= 5'd0;
         hold_stall  <= 1'b0;
         hold_bubble <= 1'b0;
         hold_flush  <= 1'b0;
      end else if (freeze_c) begin
         if (state != MEM_WAIT) begin
            ret_state <= state;
            state     <= MEM_WAIT;
         end
      end else begin
         state       <= nxt_state;
         cnt         <= nxt_cnt;
         sb_wb       <= sb_mem;
         sb_mem      <= sb_ex;
         sb_ex       <= '{valid: ~(bubble_c | flush_c), rd: rd_ID,
                          regwrite: RegWrite_ID, memread: MemRead_ID};
         ex_rs1      <= rs1_ID;
         ex_rs2      <= rs2_ID;
         hold_stall  <= stall_c;
         hold_bubble <= bubble_c;
         hold_flush  <= flush_c;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_stall, cnt_flush, cnt_wait;

   always_ff @(posedge CLOCK or negedge RST_n) begin
      if (!RST_n) begin
         cnt_stall <= '0;
         cnt_flush <= '0;
         cnt_wait  <= '0;
      end else begin
         if (!freeze_c && stall_c && cnt_stall != '1) cnt_stall <= cnt_stall + 1'b1;
         if (!freeze_c && PCSrc_EX && cnt_flush != '1) cnt_flush <= cnt_flush + 1'b1;
         if (freeze_c && cnt_wait != '1)               cnt_wait  <= cnt_wait + 1'b1;
      end
   end

   assign perf_stall = cnt_stall;
   assign perf_flush = cnt_flush;
   assign perf_wait  = cnt_wait;
`else
   assign perf_stall = '0;
   assign perf_flush = '0;
   assign perf_wait  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;
   localparam int FC = 2;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          CLOCK = 1'b0;
   logic          RST_n = 1'b0;
   logic [4:0]    rs1_ID = '0, rs2_ID = '0, rd_ID = '0;
   logic          use_rs1_ID = 0, use_rs2_ID = 0, RegWrite_ID = 0, MemRead_ID = 0;
   logic          PCSrc_EX = 0, mem_req = 0, mem_ready = 0;
   logic          stall_IF, bubble_EX, flush_ID, freeze, busy;
   logic [1:0]    fwd_A, fwd_B;
   logic [CW-1:0] perf_stall, perf_flush, perf_wait;

   always #5 CLOCK = ~CLOCK;

   hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .CLOCK(CLOCK), .RST_n(RST_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .rd_ID(rd_ID),
      .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .PCSrc_EX(PCSrc_EX),
      .mem_req(mem_req), .mem_ready(mem_ready), .stall_IF(stall_IF),
      .bubble_EX(bubble_EX), .flush_ID(flush_ID), .freeze(freeze),
      .fwd_A(fwd_A), .fwd_B(fwd_B), .busy(busy), .perf_stall(perf_stall),
      .perf_flush(perf_flush), .perf_wait(perf_wait));

   int total = 0, bad = 0;

   // model: in-flight instructions by pipeline position (0=EX, 1=MEM, 2=WB)
   bit       v[3], rw[3], mr[3];
   int       rdq[3];
   int       x_rs1, x_rs2;
   int       m_fl;        // flush cycles still owed after the current one
   bit       m_as;        // the cycle after a load-use stall
   bit       m_wait;      // previous edge was frozen
   bit       h_st, h_bu, h_fl;
   int       p_st, p_fl, p_wt;
   bit       e_st, e_bu, e_fl, e_fz, e_busy, n_as;
   int       e_fa, e_fb, n_fl;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int fwd_of(input int rs);
      if (v[1] && rw[1] && !mr[1] && rdq[1] != 0 && rdq[1] == rs) return 1;
      if (v[2] && rw[2] && rdq[2] != 0 && rdq[2] == rs) return 2;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin v[i] = 0; rw[i] = 0; mr[i] = 0; rdq[i] = 0; end
      x_rs1 = 0; x_rs2 = 0; m_fl = 0; m_as = 0; m_wait = 0;
      h_st = 0; h_bu = 0; h_fl = 0; p_st = 0; p_fl = 0; p_wt = 0;
   endtask

   task automatic eval();
      bit lu;
      lu = v[0] && mr[0] && rdq[0] != 0 &&
           ((use_rs1_ID && int'(rs1_ID) == rdq[0]) || (use_rs2_ID && int'(rs2_ID) == rdq[0]));
      e_fz = mem_req && !mem_ready;
      e_st = 0; e_bu = 0; e_fl = 0; n_fl = m_fl; n_as = 0;
      if (e_fz) begin
         e_st = h_st; e_bu = h_bu; e_fl = h_fl; n_as = m_as;
      end else if (PCSrc_EX) begin
         e_fl = 1; e_bu = 1; n_fl = FC - 1;
      end else if (m_fl > 0) begin
         e_fl = 1; n_fl = m_fl - 1;
      end else if (!m_as && lu) begin
         e_st = 1; e_bu = 1; n_as = 1;
      end
      e_busy = m_wait || m_fl > 0 || m_as;
      e_fa = fwd_of(x_rs1);
      e_fb = fwd_of(x_rs2);
   endtask

   task automatic tick();
      if (e_fz) begin
         m_wait = 1;
         if (p_wt < CMAX) p_wt++;
      end else begin
         m_wait = 0;
         for (int i = 2; i > 0; i--) begin
            v[i] = v[i-1]; rw[i] = rw[i-1]; mr[i] = mr[i-1]; rdq[i] = rdq[i-1];
         end
         v[0] = !(e_bu || e_fl); rw[0] = RegWrite_ID; mr[0] = MemRead_ID; rdq[0] = rd_ID;
         x_rs1 = rs1_ID; x_rs2 = rs2_ID;
         m_fl = n_fl; m_as = n_as;
         h_st = e_st; h_bu = e_bu; h_fl = e_fl;
         if (e_st && p_st < CMAX) p_st++;
         if (PCSrc_EX && p_fl < CMAX) p_fl++;
      end
   endtask

   task automatic compare();
      chk("stall_IF", stall_IF, e_st);
      chk("bubble_EX", bubble_EX, e_bu);
      chk("flush_ID", flush_ID, e_fl);
      chk("freeze", freeze, e_fz);
      chk("busy", busy, e_busy);
      chk("fwd_A", fwd_A, e_fa);
      chk("fwd_B", fwd_B, e_fb);
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall", perf_stall, p_st);
      chk("perf_flush", perf_flush, p_fl);
      chk("perf_wait", perf_wait, p_wt);
`else
      chk("perf_tied", int'(perf_stall | perf_flush | perf_wait), 0);
`endif
   endtask

   // called at a falling edge with inputs already driven
   task automatic cyc();
      #1;
      eval();
      compare();
      @(posedge CLOCK);
      tick();
      @(negedge CLOCK);
   endtask

   task automatic setin(input bit pc, input bit mq, input bit my, input int r1, input bit u1,
                        input int r2, input bit u2, input int rd, input bit w, input bit ld);
      PCSrc_EX = pc; mem_req = mq; mem_ready = my;
      rs1_ID = 5'(r1); use_rs1_ID = u1; rs2_ID = 5'(r2); use_rs2_ID = u2;
      rd_ID = 5'(rd); RegWrite_ID = w; MemRead_ID = ld;
   endtask

   task automatic zeros_check(input string name);
      chk({name, "_stall"}, stall_IF, 0);
      chk({name, "_bubble"}, bubble_EX, 0);
      chk({name, "_flush"}, flush_ID, 0);
      chk({name, "_freeze"}, freeze, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_fwd"}, int'({fwd_A, fwd_B}), 0);
      chk({name, "_perf"}, int'(perf_stall | perf_flush | perf_wait), 0);
   endtask

   task automatic do_reset();
      RST_n = 0;
      #1;
      zeros_check("rst");
      model_reset();
      @(posedge CLOCK);
      @(negedge CLOCK);
      RST_n = 1;
   endtask

   initial begin
      model_reset();
      #1;
      zeros_check("por");
      @(negedge CLOCK);
      @(negedge CLOCK);
      RST_n = 1;

      // load-use: lw x5 then add x6,x5,x1
      setin(0,0,0, 0,0, 0,0, 5,1,1); cyc();
      setin(0,0,0, 5,1, 1,1, 6,1,0); #1;
      chk("lu_stall", stall_IF, 1); chk("lu_bubble", bubble_EX, 1);
      cyc();
      #1; chk("lu_release", stall_IF, 0); chk("lu_busy", busy, 1);
      cyc();
      setin(0,0,0, 0,0, 0,0, 0,0,0); #1;
      chk("lu_fwdA_wb", fwd_A, 2);
      cyc();

      // ALU result forwarding from MEM, and the x0 exception
      setin(0,0,0, 0,0, 0,0, 3,1,0); cyc();
      setin(0,0,0, 0,0, 3,1, 7,1,0); cyc();
      setin(0,0,0, 0,0, 0,0, 0,0,0); #1;
      chk("fwdB_mem", fwd_B, 1);
      cyc();
      setin(0,0,0, 0,0, 0,0, 0,1,0); cyc();
      setin(0,0,0, 0,0, 0,1, 8,1,0); cyc();
      setin(0,0,0, 0,0, 0,0, 0,0,0); #1;
      chk("fwdB_x0", fwd_B, 0);
      cyc(); cyc(); cyc();

      // taken branch with a 2-cycle flush
      setin(1,0,0, 0,0, 0,0, 0,0,0); #1;
      chk("br_flush0", flush_ID, 1); chk("br_bubble0", bubble_EX, 1); chk("br_busy0", busy, 0);
      cyc();
      setin(0,0,0, 0,0, 0,0, 0,0,0); #1;
      chk("br_flush1", flush_ID, 1); chk("br_bubble1", bubble_EX, 0); chk("br_busy1", busy, 1);
      cyc();
      #1; chk("br_done", flush_ID, 0);
      cyc();

      // memory wait on top of a load-use stall
      setin(0,0,0, 0,0, 0,0, 5,1,1); cyc();
      setin(0,1,0, 5,1, 0,0, 6,1,0); #1;
      chk("mw_freeze0", freeze, 1);
      cyc();
      #1; chk("mw_busy1", busy, 1);
      cyc(); cyc();
      mem_ready = 1; #1;
      chk("mw_freeze_off", freeze, 0); chk("mw_stall", stall_IF, 1);
      cyc();
      setin(0,0,0, 0,0, 0,0, 0,0,0); cyc(); cyc();

      // load-use hit and branch together: the branch wins
      setin(0,0,0, 0,0, 0,0, 5,1,1); cyc();
      setin(1,0,0, 5,1, 0,0, 6,1,0); #1;
      chk("both_flush", flush_ID, 1); chk("both_bubble", bubble_EX, 1); chk("both_stall", stall_IF, 0);
      cyc();
      setin(0,0,0, 0,0, 0,0, 0,0,0); cyc(); cyc();

      // reset while flushing
      setin(1,0,0, 0,0, 0,0, 0,0,0); cyc();
      setin(0,0,0, 0,0, 0,0, 0,0,0); #1;
      chk("rf_busy", busy, 1);
      do_reset();

      // randomized traffic on a small register set so hazards are frequent
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            setin($urandom_range(0,1), $urandom_range(0,1), 0, 0,0, 0,0, 0,0,0);
            do_reset();
         end else begin
            setin($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30, $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35);
            cyc();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
